// File: rtl/sparse_sel_sched_if.sv
// Group-fetch and beat-stream bundle of the 2:4-sparse activation-select sequencer.
// master = producer of groups / consumer of beats, slave = the sequencer.
interface sparse_sel_sched_if #(
   parameter int DATA_W = 8,
   parameter int NNZ    = 2,
   parameter int SLOT_W = 1
);
   logic                grp_valid;
   logic                grp_ready;
   logic [4*DATA_W-1:0] act_in;
   logic [2*NNZ-1:0]    meta_in;
   logic [NNZ-1:0]      mask_in;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_act;
   logic [SLOT_W-1:0]   out_slot;
   logic                out_last;

   modport master (
      output grp_valid, act_in, meta_in, mask_in, out_ready,
      input  grp_ready, out_valid, out_act, out_slot, out_last
   );

   modport slave (
      input  grp_valid, act_in, meta_in, mask_in, out_ready,
      output grp_ready, out_valid, out_act, out_slot, out_last
   );
endinterface

// File: rtl/sparse_sel_sched.sv
// Sequencer for the 2:4-sparse activation-select path: fetches 4-activation groups with
// index metadata and streams one mux-selected activation per nonzero slot to the PE.
module mux4to1 #(
   parameter int W = 8
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  logic [1:0]   sel,
   output logic [W-1:0] y
);
   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end
endmodule

module sparse_sel_sched #(
   parameter int DATA_W = 8,
   parameter int NNZ    = 2,
   parameter int LEN_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] tile_len,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   sparse_sel_sched_if.slave bus
);
   localparam int SLOT_W = (NNZ > 1) ? $clog2(NNZ) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

   state_t              state;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    grp_cnt;
   logic [4*DATA_W-1:0] act_q;
   logic [2*NNZ-1:0]    meta_q;
   logic [NNZ-1:0]      mask_q;
   logic [SLOT_W-1:0]   slot_q;
   logic                grp_ready_q;
   logic                valid_q;
   logic                last_q;
   logic                busy_q;
   logic                done_q;

   // Lowest set mask bit at or above 'from'; MSB of the result flags that one exists.
   function automatic logic [SLOT_W:0] find_set(input logic [NNZ-1:0] m, input int from);
      logic [SLOT_W:0] r;
      r = '0;
      for (int k = NNZ - 1; k >= 0; k--)
         if (k >= from && m[k]) r = {1'b1, SLOT_W'(k)};
      return r;
   endfunction

   function automatic logic has_set_from(input logic [NNZ-1:0] m, input int from);
      logic r;
      r = 1'b0;
      for (int k = 0; k < NNZ; k++)
         if (k >= from && m[k]) r = 1'b1;
      return r;
   endfunction

   logic [SLOT_W:0] first_hit;
   logic [SLOT_W:0] next_hit;
   logic            first_alone;
   logic            next_alone;
   logic            last_grp;
   logic [1:0]      sel;

   always_comb begin
      first_hit   = find_set(bus.mask_in, 0);
      first_alone = !has_set_from(bus.mask_in, int'(first_hit[SLOT_W-1:0]) + 1);
      next_hit    = find_set(mask_q, int'(slot_q) + 1);
      next_alone  = !has_set_from(mask_q, int'(next_hit[SLOT_W-1:0]) + 1);
      last_grp    = (grp_cnt == len_q - LEN_W'(1));
      sel         = meta_q[2*int'(slot_q) +: 2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         len_q       <= '0;
         grp_cnt     <= '0;
         act_q       <= '0;
         meta_q      <= '0;
         mask_q      <= '0;
         slot_q      <= '0;
         grp_ready_q <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (flush) begin
         // Abort wins over start, handshakes and completion alike.
         state       <= IDLE;
         grp_ready_q <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  len_q   <= tile_len;
                  grp_cnt <= '0;
                  busy_q  <= 1'b1;
                  if (tile_len == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state       <= FETCH;
                     grp_ready_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (bus.grp_valid) begin
                  act_q  <= bus.act_in;
                  meta_q <= bus.meta_in;
                  mask_q <= bus.mask_in;
                  if (!first_hit[SLOT_W]) begin
                     grp_cnt <= grp_cnt + LEN_W'(1);
                     if (last_grp) begin
                        state       <= DONE;
                        done_q      <= 1'b1;
                        grp_ready_q <= 1'b0;
                     end
                  end else begin
                     state       <= ISSUE;
                     grp_ready_q <= 1'b0;
                     valid_q     <= 1'b1;
                     slot_q      <= first_hit[SLOT_W-1:0];
                     last_q      <= last_grp && first_alone;
                  end
               end
            end
            ISSUE: begin
               if (bus.out_ready) begin
                  if (next_hit[SLOT_W]) begin
                     slot_q <= next_hit[SLOT_W-1:0];
                     last_q <= last_grp && next_alone;
                  end else begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     grp_cnt <= grp_cnt + LEN_W'(1);
                     if (last_grp) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                     end else begin
                        state       <= FETCH;
                        grp_ready_q <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   mux4to1 #(.W(DATA_W)) u_mux (
      .d0  (act_q[0*DATA_W +: DATA_W]),
      .d1  (act_q[1*DATA_W +: DATA_W]),
      .d2  (act_q[2*DATA_W +: DATA_W]),
      .d3  (act_q[3*DATA_W +: DATA_W]),
      .sel (sel),
      .y   (bus.out_act)
   );

   assign bus.grp_ready = grp_ready_q;
   assign bus.out_valid = valid_q;
   assign bus.out_slot  = slot_q;
   assign bus.out_last  = last_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_sparse_sel_sched.sv
// Scoreboard bench for sparse_sel_sched: groups are expanded into expected beats by a
// slot-by-slot model, and a negedge monitor checks every beat the DUT hands over.
module tb_sparse_sel_sched;
   localparam int DATA_W = 8;
   localparam int NNZ    = 2;
   localparam int LEN_W  = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             flush;
   logic [LEN_W-1:0] tile_len;
   logic             busy;
   logic             done;

   sparse_sel_sched_if #(.DATA_W(DATA_W), .NNZ(NNZ), .SLOT_W(1)) bus ();

   sparse_sel_sched #(.DATA_W(DATA_W), .NNZ(NNZ), .LEN_W(LEN_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .tile_len (tile_len),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] act;
      logic       slot;
      logic       last;
   } beat_t;

   beat_t sb[$];
   int    n_cmp    = 0;
   int    n_bad    = 0;
   int    n_beats  = 0;
   int    done_cnt = 0;
   int    exp_done = 0;
   int    rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Each set mask bit k becomes one beat: a[meta[k]] in slot k, last on the top slot of
   // the final group.
   function automatic void model_group(input logic [31:0] a, input logic [3:0] meta,
                                       input logic [1:0] mask, input int g, input int len);
      int    top;
      int    idx;
      beat_t b;
      top = -1;
      for (int k = 0; k < NNZ; k++) if (mask[k]) top = k;
      for (int k = 0; k < NNZ; k++) begin
         if (mask[k]) begin
            idx    = int'(meta[2*k +: 2]);
            b.act  = a[8*idx +: 8];
            b.slot = 1'(k);
            b.last = (g == len - 1) && (k == top);
            sb.push_back(b);
         end
      end
   endfunction

   beat_t cur_b;
   beat_t held_b;
   beat_t exp_b;
   bit    stalled = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (bus.out_valid) begin
            cur_b = '{act: bus.out_act, slot: bus.out_slot, last: bus.out_last};
            if (stalled) chk("hold_stable", 32'(cur_b), 32'(held_b));
            if (bus.out_ready) begin
               n_beats++;
               stalled = 1'b0;
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got %0h, expected no beat", cur_b);
               end else begin
                  exp_b = sb.pop_front();
                  chk("beat", 32'(cur_b), 32'(exp_b));
               end
            end else begin
               stalled = 1'b1;
               held_b  = cur_b;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic start_tile(input int len);
      @(posedge clk);
      #1;
      start    = 1'b1;
      tile_len = LEN_W'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_group(input logic [31:0] a, input logic [3:0] m, input logic [1:0] k,
                             input int g, input int len);
      bit ok;
      ok            = 1'b0;
      bus.act_in    = a;
      bus.meta_in   = m;
      bus.mask_in   = k;
      bus.grp_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.grp_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         model_group(a, m, k, g, len);
         @(posedge clk);
         #1;
      end
      bus.grp_valid = 1'b0;
      chk("grp_accept", 32'(ok), 32'd1);
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt >= exp_done) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
      chk({name, "_count"}, 32'(done_cnt), 32'(exp_done));
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic run_random_tile(input int len);
      start_tile(len);
      for (int g = 0; g < len; g++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send_group($urandom, 4'($urandom), 2'($urandom), g, len);
      end
      exp_done++;
      wait_done("rand_tile_done");
   endtask

   int beats0;

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      flush         = 1'b0;
      tile_len      = '0;
      bus.grp_valid = 1'b0;
      bus.act_in    = '0;
      bus.meta_in   = '0;
      bus.mask_in   = '0;
      #3;
      chk("reset_outputs",
          32'({bus.out_valid, bus.out_last, bus.out_slot, busy, done, bus.grp_ready, bus.out_act}),
          32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Two-beat group, streaming ready.
      rdy_mode = 0;
      beats0   = n_beats;
      start_tile(1);
      send_group(32'h281E140A, 4'b1101, 2'b11, 0, 1);
      exp_done++;
      wait_done("t1_done");
      chk("t1_beats", 32'(n_beats - beats0), 32'd2);

      // Empty group followed by a single-slot group.
      beats0 = n_beats;
      start_tile(2);
      send_group($urandom, 4'($urandom), 2'b00, 0, 2);
      send_group(32'h11223344, 4'b1000, 2'b10, 1, 2);
      exp_done++;
      wait_done("t2_done");
      chk("t2_beats", 32'(n_beats - beats0), 32'd1);

      // First beat stalled for three cycles.
      beats0   = n_beats;
      rdy_mode = 2;
      start_tile(1);
      send_group(32'h281E140A, 4'b1101, 2'b11, 0, 1);
      repeat (3) @(negedge clk);
      chk("t3_stall_act", 32'(bus.out_act), 32'd20);
      chk("t3_stall_slot", 32'(bus.out_slot), 32'd0);
      rdy_mode = 0;
      exp_done++;
      wait_done("t3_done");
      chk("t3_beats", 32'(n_beats - beats0), 32'd2);

      // Empty tile.
      start_tile(0);
      @(negedge clk);
      chk("t4_busy_done", 32'({busy, done, bus.grp_ready}), 32'b110);
      @(negedge clk);
      chk("t4_after", 32'({busy, done, bus.grp_ready}), 32'b000);
      exp_done++;
      wait_done("t4_done");

      // Flush during ISSUE of group 3 of 8.
      start_tile(8);
      for (int g = 0; g < 3; g++) send_group($urandom, 4'($urandom), 2'($urandom), g, 8);
      send_group($urandom, 4'($urandom), 2'b11, 3, 8);
      rdy_mode = 2;
      @(negedge clk);
      chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chk("t5_after_flush", 32'({bus.out_valid, busy, bus.grp_ready}), 32'd0);
      chk("t5_pending", 32'(sb.size()), 32'd2);
      repeat (3) @(negedge clk);
      chk("t5_no_done", 32'(done_cnt), 32'(exp_done));
      sb.delete();
      rdy_mode = 1;
      run_random_tile(8);

      // Flush together with start in IDLE.
      @(posedge clk);
      #1;
      start    = 1'b1;
      flush    = 1'b1;
      tile_len = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_start", 32'({busy, bus.grp_ready}), 32'd0);

      // Start while busy is ignored.
      start_tile(3);
      send_group($urandom, 4'($urandom), 2'($urandom), 0, 3);
      @(posedge clk);
      #1;
      start    = 1'b1;
      tile_len = 8'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      send_group($urandom, 4'($urandom), 2'($urandom), 1, 3);
      send_group($urandom, 4'($urandom), 2'b01, 2, 3);
      exp_done++;
      wait_done("t6_done");

      // Asynchronous reset in the middle of ISSUE.
      rdy_mode = 0;
      start_tile(2);
      send_group(32'hA5A5A5A5, 4'b0110, 2'b11, 0, 2);
      rdy_mode = 2;
      @(negedge clk);
      chk("t7_pre_valid", 32'(bus.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t7_async_reset",
          32'({bus.out_valid, bus.out_last, bus.out_slot, busy, done, bus.grp_ready, bus.out_act}),
          32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rdy_mode = 1;

      for (int t = 0; t < 12; t++) run_random_tile($urandom_range(0, 6));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
